// File: rtl/wb_port_arbiter_pkg.sv
// Shared writeback-arbiter definitions: default widths and source index constants.
package wb_pkg;

    localparam int unsigned WB_NREQ = 3;
    localparam int unsigned WB_XLEN = 32;
    localparam int unsigned WB_RAW  = 5;

    localparam int unsigned WB_SRC_ALU = 0;
    localparam int unsigned WB_SRC_LSU = 1;
    localparam int unsigned WB_SRC_MDU = 2;

endpackage

// File: rtl/wb_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, modulo N.
module rr_pick #(
    parameter int unsigned N  = 2,
    parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx
);

    logic found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            int unsigned c;
            c = (32'(ptr) + k) % N;
            if (!found && req[c]) begin
                gnt[c] = 1'b1;
                idx    = c[PW-1:0];
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing the single regfile write port among NREQ
// writeback sources; the winner's rd/data are registered onto the port.
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned NREQ = WB_NREQ,
    parameter int unsigned XLEN = WB_XLEN,
    parameter int unsigned RAW  = WB_RAW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*RAW-1:0]  req_rd,
    input  logic [NREQ*XLEN-1:0] req_data,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 wb_stall,
    output logic                 rf_we,
    output logic [RAW-1:0]       rf_wa,
    output logic [XLEN-1:0]      rf_wd,
    output logic [31:0]          wr_count
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   idx;
    logic [PW-1:0]   ptr_next;
    logic [NREQ-1:0] gnt;
    logic            transfer;
    logic [RAW-1:0]  sel_rd;
    logic [XLEN-1:0] sel_data;

    rr_pick #(
        .N  (NREQ),
        .PW (PW)
    ) u_pick (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (idx)
    );

    // Grant is suppressed while reset is held so no source sees a phantom handshake.
    always_comb begin
        req_ready = (rst_n && !wb_stall) ? gnt : '0;
        transfer  = |req_ready;
        sel_rd    = req_rd[32'(idx)*RAW +: RAW];
        sel_data  = req_data[32'(idx)*XLEN +: XLEN];
        ptr_next  = (32'(idx) == NREQ - 1) ? '0 : idx + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (transfer) begin
            rr_ptr <= ptr_next;
        end
    end

    // rd==0 transfers release the source but never raise rf_we or bump the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_wa    <= '0;
            rf_wd    <= '0;
            wr_count <= '0;
        end else begin
            rf_we <= transfer && (sel_rd != '0);
            if (transfer) begin
                rf_wa <= sel_rd;
                rf_wd <= sel_data;
            end
            if (transfer && (sel_rd != '0)) begin
                wr_count <= wr_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed table-driven bench for wb_port_arbiter with hand-computed expectations.
module tb_wb_port_arbiter;

    logic         clk;
    logic         rst_n;
    logic [2:0]   req_valid;
    logic [14:0]  req_rd;
    logic [95:0]  req_data;
    logic [2:0]   req_ready;
    logic         wb_stall;
    logic         rf_we;
    logic [4:0]   rf_wa;
    logic [31:0]  rf_wd;
    logic [31:0]  wr_count;

    int checks;
    int errors;

    logic [31:0] rf_model [32];
    logic [2:0]  pend;
    logic [14:0] prev_rd;
    logic [95:0] prev_data;

    wb_port_arbiter #(
        .NREQ (3),
        .XLEN (32),
        .RAW  (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_rd    (req_rd),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wb_stall  (wb_stall),
        .rf_we     (rf_we),
        .rf_wa     (rf_wa),
        .rf_wd     (rf_wd),
        .wr_count  (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  valid;
        logic [14:0] rd;
        logic [95:0] data;
        logic        stall;
        logic [2:0]  ready;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] cnt;
    } vec_t;

    vec_t tbl [20];

    function automatic vec_t mk(input logic [2:0] va, input logic [4:0] r0, input logic [4:0] r1,
                                input logic [4:0] r2, input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2, input logic st, input logic [2:0] rdy,
                                input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic [31:0] cnt);
        vec_t v;
        v.valid = va;
        v.rd    = {r2, r1, r0};
        v.data  = {d2, d1, d0};
        v.stall = st;
        v.ready = rdy;
        v.we    = we;
        v.wa    = wa;
        v.wd    = wd;
        v.cnt   = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Regfile model fed by committed writes; rf_we high during a cycle commits at its end.
    always @(posedge clk) begin
        if (rst_n && rf_we) rf_model[rf_wa] <= rf_wd;
    end

    // Source protocol: a pending (valid, not ready) source must hold valid, rd and data.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (pend[i]) begin
                    assert (req_valid[i] && req_rd[i*5 +: 5] == prev_rd[i*5 +: 5]
                            && req_data[i*32 +: 32] == prev_data[i*32 +: 32])
                    else $error("source %0d broke the hold-until-ready protocol", i);
                end
            end
            pend      <= req_valid & ~req_ready;
            prev_rd   <= req_rd;
            prev_data <= req_data;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 32; i++) rf_model[i] = '0;

        //            valid  r0 r1 r2 d0     d1            d2     st rdy    we wa wd            cnt
        tbl[0]  = mk(3'b111, 1, 2, 3, 32'hA, 32'hB,        32'hC, 0, 3'b001, 1, 1, 32'hA,        1);
        tbl[1]  = mk(3'b111, 1, 2, 3, 32'hA, 32'hB,        32'hC, 0, 3'b010, 1, 2, 32'hB,        2);
        tbl[2]  = mk(3'b111, 1, 2, 3, 32'hA, 32'hB,        32'hC, 0, 3'b100, 1, 3, 32'hC,        3);
        tbl[3]  = mk(3'b111, 1, 2, 3, 32'hA, 32'hB,        32'hC, 0, 3'b001, 1, 1, 32'hA,        4);
        tbl[4]  = mk(3'b111, 1, 2, 3, 32'hA, 32'hB,        32'hC, 0, 3'b010, 1, 2, 32'hB,        5);
        tbl[5]  = mk(3'b111, 1, 2, 3, 32'hA, 32'hB,        32'hC, 0, 3'b100, 1, 3, 32'hC,        6);
        tbl[6]  = mk(3'b011, 1, 2, 0, 32'hA, 32'hB,        32'h0, 0, 3'b001, 1, 1, 32'hA,        7);
        tbl[7]  = mk(3'b010, 0, 2, 0, 32'h0, 32'hB,        32'h0, 0, 3'b010, 1, 2, 32'hB,        8);
        tbl[8]  = mk(3'b010, 0, 0, 0, 32'h0, 32'hDEADBEEF, 32'h0, 0, 3'b010, 0, 0, 32'hDEADBEEF, 8);
        tbl[9]  = mk(3'b100, 0, 0, 7, 32'h0, 32'h0,   32'h1234, 1, 3'b000, 0, 0, 32'hDEADBEEF, 8);
        tbl[10] = mk(3'b100, 0, 0, 7, 32'h0, 32'h0,   32'h1234, 1, 3'b000, 0, 0, 32'hDEADBEEF, 8);
        tbl[11] = mk(3'b100, 0, 0, 7, 32'h0, 32'h0,   32'h1234, 1, 3'b000, 0, 0, 32'hDEADBEEF, 8);
        tbl[12] = mk(3'b100, 0, 0, 7, 32'h0, 32'h0,   32'h1234, 0, 3'b100, 1, 7, 32'h1234,     9);
        tbl[13] = mk(3'b001, 4, 0, 0, 32'h44, 32'h0,       32'h0, 0, 3'b001, 1, 4, 32'h44,      10);
        tbl[14] = mk(3'b001, 4, 0, 0, 32'h44, 32'h0,       32'h0, 1, 3'b000, 0, 4, 32'h44,      10);
        tbl[15] = mk(3'b001, 4, 0, 0, 32'h44, 32'h0,       32'h0, 0, 3'b001, 1, 4, 32'h44,      11);
        tbl[16] = mk(3'b100, 0, 0, 9, 32'h0,  32'h0,      32'h99, 0, 3'b100, 1, 9, 32'h99,      12);
        tbl[17] = mk(3'b011, 5, 5, 0, 32'h11, 32'h22,      32'h0, 0, 3'b001, 1, 5, 32'h11,      13);
        tbl[18] = mk(3'b010, 5, 5, 0, 32'h11, 32'h22,      32'h0, 0, 3'b010, 1, 5, 32'h22,      14);
        tbl[19] = mk(3'b000, 0, 0, 0, 32'h0,  32'h0,       32'h0, 0, 3'b000, 0, 5, 32'h22,      14);

        rst_n     = 1'b0;
        wb_stall  = 1'b0;
        req_valid = 3'b111;
        req_rd    = {5'd3, 5'd2, 5'd1};
        req_data  = {32'hC, 32'hB, 32'hA};
        #12;
        chk("reset_ready", 32'(req_ready), 32'h0);
        chk("reset_we",    32'(rf_we),     32'h0);
        chk("reset_count", wr_count,       32'h0);
        chk("reset_wa",    32'(rf_wa),     32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("first_grant", 32'(req_ready), 32'h1);

        for (int unsigned n = 0; n < 20; n++) begin
            req_valid = tbl[n].valid;
            req_rd    = tbl[n].rd;
            req_data  = tbl[n].data;
            wb_stall  = tbl[n].stall;
            #1;
            chk($sformatf("v%0d_ready", n), 32'(req_ready), 32'(tbl[n].ready));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_we", n),  32'(rf_we), 32'(tbl[n].we));
            chk($sformatf("v%0d_wa", n),  32'(rf_wa), 32'(tbl[n].wa));
            chk($sformatf("v%0d_wd", n),  rf_wd,      tbl[n].wd);
            chk($sformatf("v%0d_cnt", n), wr_count,   tbl[n].cnt);
            @(negedge clk);
        end

        chk("collision_final_rf5", rf_model[5], 32'h22);
        chk("rd0_not_written",     rf_model[0], 32'h0);

        // Async reset between grant and commit drops the pending write.
        req_valid = 3'b001;
        req_rd    = {5'd0, 5'd0, 5'd3};
        req_data  = {32'h0, 32'h0, 32'h77};
        #1;
        chk("midrst_grant", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        chk("midrst_we_before", 32'(rf_we), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_we_after",    32'(rf_we),     32'h0);
        chk("midrst_ready_after", 32'(req_ready), 32'h0);
        chk("midrst_count",       wr_count,       32'h0);
        @(negedge clk);
        req_valid = 3'b000;
        rst_n     = 1'b1;

        // Counter wrap.
        @(negedge clk);
        force dut.wr_count = 32'hFFFF_FFFF;
        #1;
        release dut.wr_count;
        #1;
        chk("wrap_preload", wr_count, 32'hFFFF_FFFF);
        req_valid = 3'b010;
        req_rd    = {5'd0, 5'd6, 5'd0};
        req_data  = {32'h0, 32'h66, 32'h0};
        #1;
        chk("wrap_grant", 32'(req_ready), 32'h2);
        @(posedge clk);
        #1;
        chk("wrap_we",    32'(rf_we), 32'h1);
        chk("wrap_wa",    32'(rf_wa), 32'h6);
        chk("wrap_count", wr_count,   32'h0);
        @(negedge clk);
        req_valid = 3'b000;
        @(posedge clk);
        #1;
        chk("wrap_no_repeat", 32'(rf_we), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
